// File: rtl/bus_request_arbiter_pkg.sv
// Shared types for the code/data bus request arbiter: FSM states, requester ids and the
// bit positions used in the two-wide eligible/grant vectors.
package bus_request_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUS_CODE = 2'd1,
    BUS_DATA = 2'd2
  } bus_arb_state_t;

  typedef enum logic {
    REQ_CODE = 1'b0,
    REQ_DATA = 1'b1
  } bus_requester_t;

  localparam int unsigned NumReq  = 2;
  localparam int unsigned CodeBit = 0;
  localparam int unsigned DataBit = 1;

  // Bus-owning state that serves a given requester.
  function automatic bus_arb_state_t bus_state_for(input bus_requester_t req);
    return (req == REQ_CODE) ? BUS_CODE : BUS_DATA;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr2.sv
// Combinational two-way round-robin picker. While the data side holds the lock, the code
// requester is masked so a read-modify-write sequence cannot be split.
module bus_arbiter_rr2
  import bus_request_arbiter_pkg::*;
(
  input  logic [NumReq-1:0] eligible_i,
  input  bus_requester_t    last_grant_i,
  input  logic              lock_i,
  output logic [NumReq-1:0] grant_o
);

  logic [NumReq-1:0] masked;

  always_comb begin
    masked = eligible_i;
    if (lock_i) begin
      masked[CodeBit] = 1'b0;
    end

    grant_o = '0;
    unique case (masked)
      2'b01:   grant_o[CodeBit] = 1'b1;
      2'b10:   grant_o[DataBit] = 1'b1;
      // Tie goes to whoever did not win last time.
      2'b11: begin
        if (last_grant_i == REQ_DATA) begin
          grant_o[CodeBit] = 1'b1;
        end else begin
          grant_o[DataBit] = 1'b1;
        end
      end
      default: grant_o = '0;
    endcase
  end

endmodule

// File: rtl/bus_request_arbiter.sv
// Shares the bus-interface-unit port between the fetch (code) and execute (data) requesters:
// registers the winning request onto the bus and returns data plus a one-cycle ready pulse.
module bus_request_arbiter
  import bus_request_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              i_code_vaild,
  input  logic [ADDR_W-1:0] i_code_address,
  output logic              o_code_ready,
  output logic [DATA_W-1:0] o_code_data_read,

  input  logic              i_data_vaild,
  input  logic              i_data_write_enable,
  input  logic              i_data_lock,
  input  logic [ADDR_W-1:0] i_data_address,
  input  logic [DATA_W-1:0] i_data_data_write,
  output logic              o_data_ready,
  output logic [DATA_W-1:0] o_data_data_read,

  output logic              o_bus_vaild,
  input  logic              i_bus_ready,
  output logic              o_bus_write_enable,
  output logic [ADDR_W-1:0] o_bus_address,
  output logic [DATA_W-1:0] o_bus_data_write,
  input  logic [DATA_W-1:0] i_bus_data_read,
  output logic              o_bus_busy
);

  bus_arb_state_t state_q, state_d;
  bus_requester_t last_grant_q, last_grant_d;
  logic           lock_held_q, lock_held_d;

  logic              bus_vaild_q, bus_vaild_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

  logic              code_ready_q, code_ready_d;
  logic              data_ready_q, data_ready_d;
  logic [DATA_W-1:0] code_rdata_q, code_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

  logic [NumReq-1:0] eligible;
  logic [NumReq-1:0] grant;

  // A requester being acked this cycle still shows its old valid; mask it so it is not
  // served twice for one request.
  always_comb begin
    eligible          = '0;
    eligible[CodeBit] = i_code_vaild & ~code_ready_q;
    eligible[DataBit] = i_data_vaild & ~data_ready_q;
  end

  bus_arbiter_rr2 u_rr2 (
    .eligible_i   (eligible),
    .last_grant_i (last_grant_q),
    .lock_i       (lock_held_q),
    .grant_o      (grant)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_held_d  = lock_held_q;
    bus_vaild_d  = bus_vaild_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    code_ready_d = 1'b0;
    data_ready_d = 1'b0;
    code_rdata_d = code_rdata_q;
    data_rdata_d = data_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (!i_data_vaild && !i_data_lock) begin
          lock_held_d = 1'b0;
        end
        if (grant[CodeBit]) begin
          state_d      = bus_state_for(REQ_CODE);
          last_grant_d = REQ_CODE;
          bus_vaild_d  = 1'b1;
          bus_we_d     = 1'b0;
          bus_addr_d   = i_code_address;
          bus_wdata_d  = '0;
        end else if (grant[DataBit]) begin
          state_d      = bus_state_for(REQ_DATA);
          last_grant_d = REQ_DATA;
          bus_vaild_d  = 1'b1;
          bus_we_d     = i_data_write_enable;
          bus_addr_d   = i_data_address;
          bus_wdata_d  = i_data_data_write;
        end
      end

      BUS_CODE: begin
        if (i_bus_ready) begin
          state_d      = IDLE;
          bus_vaild_d  = 1'b0;
          code_rdata_d = i_bus_data_read;
          code_ready_d = 1'b1;
        end
      end

      BUS_DATA: begin
        if (i_bus_ready) begin
          state_d      = IDLE;
          bus_vaild_d  = 1'b0;
          data_rdata_d = i_bus_data_read;
          data_ready_d = 1'b1;
          lock_held_d  = i_data_lock;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_DATA;
      lock_held_q  <= 1'b0;
      bus_vaild_q  <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      code_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
      code_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_held_q  <= lock_held_d;
      bus_vaild_q  <= bus_vaild_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      code_ready_q <= code_ready_d;
      data_ready_q <= data_ready_d;
      code_rdata_q <= code_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign o_bus_vaild        = bus_vaild_q;
  assign o_bus_write_enable = bus_we_q;
  assign o_bus_address      = bus_addr_q;
  assign o_bus_data_write   = bus_wdata_q;
  assign o_code_ready       = code_ready_q;
  assign o_code_data_read   = code_rdata_q;
  assign o_data_ready       = data_ready_q;
  assign o_data_data_read   = data_rdata_q;
  assign o_bus_busy         = (state_q != IDLE);

endmodule

// File: doc/bus_request_arbiter.md
# bus_request_arbiter

Shares the single bus-interface-unit port between the instruction-fetch code requester and the execute-unit data requester. It arbitrates round-robin with a data-side lock for read-modify-write sequences. It registers the granted request onto the bus, waits for the bus handshake, and returns the read data and a one-cycle ready pulse to the winning requester. It sits between instruction_fetch / execute unit and the bus interface unit.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- i_code_vaild  in  1  fetch read request; held until o_code_ready
- i_code_address  in  ADDR_W  fetch address
- o_code_ready  out  1  one-cycle pulse: o_code_data_read valid
- o_code_data_read  out  DATA_W  fetched word
- i_data_vaild  in  1  execute-unit request; held until o_data_ready
- i_data_write_enable  in  1  1 = write, 0 = read
- i_data_lock  in  1  keep data ownership after this transfer
- i_data_address  in  ADDR_W  data address
- i_data_data_write  in  DATA_W  write data
- o_data_ready  out  1  one-cycle completion pulse
- o_data_data_read  out  DATA_W  read data (undefined on writes, last value held)
- o_bus_vaild  out  1  bus request
- i_bus_ready  in  1  bus transfer complete
- o_bus_write_enable, o_bus_address, o_bus_data_write  out  1/ADDR_W/DATA_W  registered request
- i_bus_data_read  in  DATA_W  bus read data, valid with i_bus_ready
- o_bus_busy  out  1  arbiter owns an outstanding transfer (state != IDLE)

## Operation
- States: IDLE, BUS_CODE, BUS_DATA.
- IDLE: eligible requester = valid and not receiving a ready pulse this cycle (ack mask prevents double-serving a held valid).
  - lock_held=1: only data eligible; code waits.
  - one eligible: grant it.
  - both eligible: grant the one not in last_grant; last_grant resets to DATA, so code wins the first tie.
  - On grant: latch address/write_enable/write data, o_bus_vaild<=1, update last_grant, go BUS_x.
- BUS_x: hold o_bus_vaild and latched fields stable; on i_bus_ready: o_bus_vaild<=0, capture i_bus_data_read into requester's data_read register, pulse that requester's ready next cycle, go IDLE.
- Code transfers are always reads (o_bus_write_enable=0).
- lock_held: set on completion of a data transfer with i_data_lock=1; cleared on completion of a data transfer with i_data_lock=0, or in IDLE when i_data_vaild=0 and i_data_lock=0.
- Requester dropping valid while in BUS_x: transfer still completes; ready pulse still issued.
- Reset (any cycle, including mid-transfer): state=IDLE, last_grant=DATA, lock_held=0, all outputs 0 (o_bus_vaild, o_bus_write_enable, o_bus_address, o_bus_data_write, both ready, both data_read, o_bus_busy). Aborted transfer is never acknowledged.

## Timing
- Request seen in IDLE at cycle N -> o_bus_vaild at N+1.
- i_bus_ready at cycle M -> o_bus_vaild low at M+1, requester ready pulse + data at M+1, arbiter back in IDLE at M+1.
- Minimum turnaround: new grant evaluated at M+1, o_bus_vaild again at M+2.
- i_bus_ready already high at N+1 -> ready pulse at N+2 (3-cycle minimum latency).
- i_bus_ready ignored in IDLE.
- Ready pulses exactly one cycle; never both in the same cycle.

## Structure
- Shared package (definition.h / package): state enum bus_arb_state_t {IDLE, BUS_CODE, BUS_DATA}, requester enum bus_requester_t {REQ_CODE, REQ_DATA}.
- One sub-module natural: bus_arbiter_rr2, a combinational 2-way round-robin picker (inputs: eligible[1:0], last_grant, lock; output: grant). Everything else is in the top.

## Test plan
- Code-only read 0x0000_1000, bus_ready 2 cycles after o_bus_vaild, data 0x8B55_EC83 -> o_code_ready pulse at M+1 with 0x8B55_EC83, o_data_ready never high.
- Both request after reset (code 0x100, data write 0x200/0xDEAD_BEEF) -> code served first, then data; bus sees write_enable=1, data 0xDEAD_BEEF; third tie goes code.
- Data lock: data with lock=1 completes, both request -> data granted again, code waits until a data transfer with lock=0 completes.
- Held valid: code keeps i_code_vaild high across its ready pulse -> exactly one new bus request starts after the ack cycle, no duplicate same-cycle grant.
- Reset low in BUS_DATA with bus_ready pending -> all outputs 0 immediately, no o_data_ready, next request after release starts cleanly in IDLE.
- Zero-wait bus (i_bus_ready tied 1) -> back-to-back alternating code/data, ready pulse every 2 cycles, 3-cycle latency each.
